boot_loader: RTL

- Single-clock loader between a host byte stream and `memory_block`'s write port.
- Keeps the 6502 `proc` in reset while the program image is loaded into memory.
- After the last byte it writes the reset vector (0xFFFC/0xFFFD), then releases `proc_resetn`.
- Replaces `.mif` preloading in benches and on hardware, so it sits directly upstream of the memory/processor pair.

---
 rtl/boot_pkg.sv | 20 ++
 rtl/boot_loader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader.
// Contents: loader state encoding and the 6502 vector-area addresses.
// No ports; imported by boot_loader.
package boot_pkg;

    typedef enum logic [2:0] {
        LOAD,
        VEC_LO,
        VEC_HI,
        HOLD,
        RUN,
        ERROR
    } state_t;

    localparam logic [15:0] VEC_RESET_LO  = 16'hFFFC;
    localparam logic [15:0] VEC_RESET_HI  = 16'hFFFD;
    // Image bytes may not land at or above this address (NMI/RESET/IRQ vectors).
    localparam logic [15:0] VEC_AREA_BASE = 16'hFFFA;

endpackage

// File: rtl/boot_loader.sv
// Loads a host byte stream into memory_block, writes the 6502 reset vector,
// then releases proc_resetn after RELEASE_DELAY cycles. All outputs registered.
// Ports: clk/resetn; host in_valid/in_data/in_last -> in_ready; memory write
// port mem_en/mem_we/mem_addr/mem_wr_data; proc_resetn, load_count, done, error.
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE     = 16'h0200,
    parameter logic [15:0] START_ADDR    = 16'h0200,
    parameter int          RELEASE_DELAY = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wr_data,
    output logic        proc_resetn,
    output logic [15:0] load_count,
    output logic        done,
    output logic        error
);

    localparam logic [7:0] HOLD_INIT = 8'(RELEASE_DELAY);

    state_t      state;
    logic [15:0] ptr;
    logic [7:0]  hold_cnt;
    logic        accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= LOAD;
            ptr         <= LOAD_BASE;
            hold_cnt    <= '0;
            in_ready    <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            proc_resetn <= 1'b0;
            load_count  <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            // Write strobes are single-cycle; address/data hold between writes.
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (ptr >= VEC_AREA_BASE) begin
                            // Overflow byte is dropped rather than clobbering the vectors.
                            state    <= ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            mem_en      <= 1'b1;
                            mem_we      <= 1'b1;
                            mem_addr    <= ptr;
                            mem_wr_data <= in_data;
                            ptr         <= ptr + 16'd1;
                            if (load_count != 16'hFFFF) begin
                                load_count <= load_count + 16'd1;
                            end
                            if (in_last) begin
                                state    <= VEC_LO;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end
                VEC_LO: begin
                    mem_en      <= 1'b1;
                    mem_we      <= 1'b1;
                    mem_addr    <= VEC_RESET_LO;
                    mem_wr_data <= START_ADDR[7:0];
                    state       <= VEC_HI;
                end
                VEC_HI: begin
                    mem_en      <= 1'b1;
                    mem_we      <= 1'b1;
                    mem_addr    <= VEC_RESET_HI;
                    mem_wr_data <= START_ADDR[15:8];
                    hold_cnt    <= HOLD_INIT;
                    state       <= HOLD;
                end
                HOLD: begin
                    // Counter counts down to zero, release happens on the edge after.
                    if (hold_cnt == 8'd0) begin
                        proc_resetn <= 1'b1;
                        done        <= 1'b1;
                        state       <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                RUN: begin
                    in_ready <= 1'b0;
                end
                ERROR: begin
                    in_ready <= 1'b0;
                end
                default: begin
                    state    <= ERROR;
                    in_ready <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule
